dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the sin/cos DDS. It latches a sweep configuration and steps the DDS frequency word from a start value to a stop value, upward or downward, holding each point for a programmable dwell. It drives the DDS `fre` and `phase_rst` inputs directly and reports busy, done and the current point index to the host logic. It runs in the `clk_100M` domain alongside the DDS.

## Interface
- `PHASE_SYNC`, default 1: when 1, pulse `phase_rst` at the first point of every sweep pass.
- `STEP_RST`, default 0: when 1, also pulse `phase_rst` at every subsequent point.
- `clk_100M`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each cycle; begins a sweep when idle.
- `stop`  in  1  aborts the sweep; has priority over `start`.
- `repeat_en`  in  1  latched at start; 1 means restart from `f_start` after the last point.
- `f_start`  in  25  first frequency word, latched at start.
- `f_stop`  in  25  last frequency word, latched at start.
- `f_step`  in  25  step magnitude, latched at start.
- `dwell`  in  24  cycles per point, latched at start; 0 is treated as 1.
- `fre`  out  25  registered frequency word to the DDS.
- `phase_rst`  out  1  registered one-cycle phase-accumulator reset pulse to the DDS.
- `busy`  out  1  high while a sweep is active.
- `done`  out  1  one-cycle pulse after the last point of a non-repeating sweep.
- `point_idx`  out  16  index of the current point (0 = `f_start`); saturates at 65535.

## Operation
- FSM states and transitions:
  - IDLE --start & !stop--> DWELL. Load configuration, `fre`=`f_start`, `point_idx`=0.
  - DWELL --dwell count expired, not last point--> DWELL (next point).
  - DWELL --dwell count expired, last point, `repeat_en`=1--> DWELL (restart at `f_start`).
  - DWELL --dwell count expired, last point, `repeat_en`=0--> IDLE, with `done` pulsed.
  - Any state --stop--> IDLE.
- Direction is latched at start: down when `f_stop` < `f_start`, otherwise up.
- Next point:
  - Up: `cur`+`f_step`. Down: `cur`−`f_step`.
  - Computed at 26-bit width so it cannot wrap.
  - If the result passes or equals `f_stop`, it is clamped to `f_stop`, and that point is the last.
- Special cases:
  - `f_start` == `f_stop`: single-point sweep.
  - `f_step` == 0 with `f_start` ≠ `f_stop`: single-point sweep at `f_start`.
- `phase_rst`:
  - High for exactly the first cycle of point 0 of each pass when `PHASE_SYNC`=1.
  - High for the first cycle of every other point when `STEP_RST`=1.
  - Otherwise low.
- `stop`:
  - Next cycle: `busy`=0, no `done` pulse, `phase_rst`=0.
  - `fre` holds its last value.
  - `stop` and `start` high together: `stop` wins, nothing starts.
- `start` while busy is ignored, and the configuration inputs are not re-sampled. A new `start` in the cycle after `done` is accepted.
- `point_idx` increments on each point change, resets to 0 on each pass restart, and saturates at 65535.
- Reset (asynchronous, any state, including mid-sweep): state IDLE; `fre`=0, `phase_rst`=0, `busy`=0, `done`=0, `point_idx`=0; dwell counter cleared.

## Timing
- Let D = max(`dwell`,1). `start` accepted at edge N gives:
  - `fre`=`f_start`, `busy`=1 and (with `PHASE_SYNC`) `phase_rst`=1 visible after edge N.
  - Point k is held on `fre` for exactly D cycles, starting after edge N+k·D.
- Last point: it is held D cycles. Then, non-repeating:
  - `busy`=0 and `done`=1 for one cycle.
  - `fre` keeps `f_stop`.
- Repeat:
  - `fre`=`f_start` on the cycle immediately after the last point's D cycles.
  - No idle gap and no `done`.
- `stop` sampled at edge M: `busy`=0 after edge M.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-sweep: assert `rst_n`=0 during DWELL → all outputs 0 immediately. `start` after release → sweep restarts normally.
- Up sweep: `f_start`=1000, `f_stop`=1010, `f_step`=3, `dwell`=4.
  - `fre` = 1000, 1003, 1006, 1009, 1010, each held 4 cycles; `point_idx` 0..4.
  - Then a 1-cycle `done`, `busy` low, `fre` stays 1010.
  - `phase_rst` pulses only in the first cycle.
- Down sweep with repeat: `f_start`=500, `f_stop`=490, `f_step`=5, `dwell`=0, `repeat_en`=1.
  - `fre` = 500, 495, 490, 500, 495, …, 1 cycle each.
  - `phase_rst` in each cycle where `fre`=500; never `done`.
- Degenerate cases: `f_step`=0 and `dwell`=2 → one point at `f_start` for 2 cycles, then `done`. `f_start`=`f_stop`=7 → same behaviour.
- `STEP_RST`=1, up sweep 0→20, step 10, `dwell`=3 → `phase_rst` high in the first cycle of each of the 3 points.
- Control races:
  - `start` and `stop` high together in IDLE → nothing starts.
  - `stop` mid-sweep → `busy`=0 next cycle, `fre` held, no `done`.
  - `start` pulsed while busy → ignored; configuration unchanged.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the sin/cos DDS: steps the DDS frequency word
// from a start value to a stop value, holding each point for a programmable dwell.
module dds_sweep_ctrl #(
    parameter bit PHASE_SYNC = 1'b1,
    parameter bit STEP_RST   = 1'b0
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        repeat_en,
    input  logic [24:0] f_start,
    input  logic [24:0] f_stop,
    input  logic [24:0] f_step,
    input  logic [23:0] dwell,
    output logic [24:0] fre,
    output logic        phase_rst,
    output logic        busy,
    output logic        done,
    output logic [15:0] point_idx
);

    typedef enum logic {S_IDLE, S_DWELL} state_t;

    state_t      r_state, w_state_nxt;

    logic [24:0] r_cfg_start, r_cfg_stop, r_cfg_step;
    logic [23:0] r_dwell_m1, r_cnt;
    logic        r_down, r_repeat, r_single, r_last;
    logic [24:0] r_fre;
    logic        r_phase_rst, r_busy, r_done;
    logic [15:0] r_idx;

    logic [24:0] w_cfg_start, w_cfg_stop, w_cfg_step;
    logic [23:0] w_dwell_m1, w_cnt;
    logic        w_down, w_repeat, w_single, w_last;
    logic [24:0] w_fre;
    logic        w_phase_rst, w_busy, w_done;
    logic [15:0] w_idx;

    logic [25:0] w_sum;
    logic        w_clamp;

    // One extra bit keeps the step from wrapping; a set MSB on a down step means it went below zero.
    assign w_sum   = r_down ? ({1'b0, r_fre} - {1'b0, r_cfg_step})
                            : ({1'b0, r_fre} + {1'b0, r_cfg_step});
    assign w_clamp = r_down ? (w_sum[25] || (w_sum <= {1'b0, r_cfg_stop}))
                            : (w_sum >= {1'b0, r_cfg_stop});

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_start = r_cfg_start;
        w_cfg_stop  = r_cfg_stop;
        w_cfg_step  = r_cfg_step;
        w_dwell_m1  = r_dwell_m1;
        w_cnt       = r_cnt;
        w_down      = r_down;
        w_repeat    = r_repeat;
        w_single    = r_single;
        w_last      = r_last;
        w_fre       = r_fre;
        w_busy      = r_busy;
        w_idx       = r_idx;
        w_phase_rst = 1'b0;
        w_done      = 1'b0;

        if (stop) begin
            w_state_nxt = S_IDLE;
            w_busy      = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_DWELL;
                        w_cfg_start = f_start;
                        w_cfg_stop  = f_stop;
                        w_cfg_step  = f_step;
                        w_down      = (f_stop < f_start);
                        w_repeat    = repeat_en;
                        w_single    = (f_start == f_stop) || (f_step == '0);
                        w_last      = (f_start == f_stop) || (f_step == '0);
                        w_dwell_m1  = (dwell == '0) ? '0 : dwell - 24'd1;
                        w_cnt       = (dwell == '0) ? '0 : dwell - 24'd1;
                        w_fre       = f_start;
                        w_idx       = '0;
                        w_busy      = 1'b1;
                        w_phase_rst = PHASE_SYNC;
                    end
                end
                S_DWELL: begin
                    if (r_cnt != '0) begin
                        w_cnt = r_cnt - 24'd1;
                    end else if (!r_last) begin
                        w_fre       = w_clamp ? r_cfg_stop : w_sum[24:0];
                        w_last      = w_clamp;
                        w_idx       = (r_idx == '1) ? r_idx : r_idx + 16'd1;
                        w_cnt       = r_dwell_m1;
                        w_phase_rst = STEP_RST;
                    end else if (r_repeat) begin
                        w_fre       = r_cfg_start;
                        w_last      = r_single;
                        w_idx       = '0;
                        w_cnt       = r_dwell_m1;
                        w_phase_rst = PHASE_SYNC;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy      = 1'b0;
                        w_done      = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_start <= '0;
            r_cfg_stop  <= '0;
            r_cfg_step  <= '0;
            r_dwell_m1  <= '0;
            r_cnt       <= '0;
            r_down      <= 1'b0;
            r_repeat    <= 1'b0;
            r_single    <= 1'b0;
            r_last      <= 1'b0;
            r_fre       <= '0;
            r_phase_rst <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_cfg_start <= w_cfg_start;
            r_cfg_stop  <= w_cfg_stop;
            r_cfg_step  <= w_cfg_step;
            r_dwell_m1  <= w_dwell_m1;
            r_cnt       <= w_cnt;
            r_down      <= w_down;
            r_repeat    <= w_repeat;
            r_single    <= w_single;
            r_last      <= w_last;
            r_fre       <= w_fre;
            r_phase_rst <= w_phase_rst;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_idx       <= w_idx;
        end
    end

    assign fre       = r_fre;
    assign phase_rst = r_phase_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign point_idx = r_idx;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a point-list sweep model checked every cycle against two
// instances (step phase reset off/on), plus directed literal checks and randomized sweeps.
module tb_dds_sweep_ctrl;

    localparam int unsigned FMAX = 32'h01FF_FFFF;

    logic        clk_100M = 1'b0;
    logic        rst_n;
    logic        start, stop, repeat_en;
    logic [24:0] f_start, f_stop, f_step;
    logic [23:0] dwell;

    logic [24:0] fre_a, fre_b;
    logic        prst_a, prst_b, busy_a, busy_b, done_a, done_b;
    logic [15:0] idx_a, idx_b;

    always #5 clk_100M = ~clk_100M;

    dds_sweep_ctrl #(.PHASE_SYNC(1'b1), .STEP_RST(1'b0)) u_dut_a (
        .clk_100M (clk_100M), .rst_n (rst_n), .start (start), .stop (stop),
        .repeat_en (repeat_en), .f_start (f_start), .f_stop (f_stop), .f_step (f_step),
        .dwell (dwell), .fre (fre_a), .phase_rst (prst_a), .busy (busy_a),
        .done (done_a), .point_idx (idx_a)
    );

    dds_sweep_ctrl #(.PHASE_SYNC(1'b1), .STEP_RST(1'b1)) u_dut_b (
        .clk_100M (clk_100M), .rst_n (rst_n), .start (start), .stop (stop),
        .repeat_en (repeat_en), .f_start (f_start), .f_stop (f_stop), .f_step (f_step),
        .dwell (dwell), .fre (fre_b), .phase_rst (prst_b), .busy (busy_b),
        .done (done_b), .point_idx (idx_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: the whole sweep is a list of frequency points; a pass walks the list.
    longint m_pts[$];
    longint m_fre;
    bit     m_active, m_done, m_first, m_point0, m_repeat;
    int     m_k, m_cnt, m_d, m_idx;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_points(input longint fs, input longint fe, input longint st);
        longint cur, nxt;
        bit     fin;
        m_pts.delete();
        m_pts.push_back(fs);
        fin = (fs == fe) || (st == 0);
        cur = fs;
        while (!fin) begin
            nxt = (fe < fs) ? cur - st : cur + st;
            if ((fe < fs) ? (nxt <= fe) : (nxt >= fe)) begin
                m_pts.push_back(fe);
                fin = 1'b1;
            end else begin
                m_pts.push_back(nxt);
                cur = nxt;
            end
        end
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_first  = 1'b0;
        m_point0 = 1'b0;
        m_fre    = 0;
        m_idx    = 0;
        m_k      = 0;
        m_cnt    = 0;
    endfunction

    function automatic void model_step();
        m_done  = 1'b0;
        m_first = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (stop) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                build_points(longint'(f_start), longint'(f_stop), longint'(f_step));
                m_d      = (dwell == 24'd0) ? 1 : int'(dwell);
                m_repeat = repeat_en;
                m_active = 1'b1;
                m_k      = 0;
                m_cnt    = 0;
                m_fre    = m_pts[0];
                m_idx    = 0;
                m_first  = 1'b1;
                m_point0 = 1'b1;
            end
        end else begin
            m_cnt++;
            if (m_cnt >= m_d) begin
                m_cnt = 0;
                if (m_k + 1 < m_pts.size()) begin
                    m_k++;
                    m_fre    = m_pts[m_k];
                    m_idx    = (m_k > 65535) ? 65535 : m_k;
                    m_first  = 1'b1;
                    m_point0 = 1'b0;
                end else if (m_repeat) begin
                    m_k      = 0;
                    m_fre    = m_pts[0];
                    m_idx    = 0;
                    m_first  = 1'b1;
                    m_point0 = 1'b1;
                end else begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk_100M);
            model_step();
            @(negedge clk_100M);
            if (!rst_n) model_reset();
            chk("fre_a",   longint'(fre_a),  m_fre);
            chk("fre_b",   longint'(fre_b),  m_fre);
            chk("busy_a",  longint'(busy_a), longint'(m_active));
            chk("busy_b",  longint'(busy_b), longint'(m_active));
            chk("done_a",  longint'(done_a), longint'(m_done));
            chk("done_b",  longint'(done_b), longint'(m_done));
            chk("idx_a",   longint'(idx_a),  longint'(m_idx));
            chk("idx_b",   longint'(idx_b),  longint'(m_idx));
            chk("prst_a",  longint'(prst_a), longint'(m_first && m_point0));
            chk("prst_b",  longint'(prst_b), longint'(m_first));
        end
    end

    task automatic tick();
        @(posedge clk_100M);
        #2;
    endtask

    task automatic set_cfg(input int unsigned fs, input int unsigned fe, input int unsigned st,
                           input int unsigned dw, input bit rep);
        f_start   = 25'(fs);
        f_stop    = 25'(fe);
        f_step    = 25'(st);
        dwell     = 24'(dw);
        repeat_en = rep;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        for (int unsigned c = 0; c < budget && m_active; c++) tick();
        if (m_active) begin
            n_vec++;
            n_err++;
            $display("FAIL sweep_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fre"},  longint'(fre_a),  0);
        chk({tag, "_busy"}, longint'(busy_a), 0);
        chk({tag, "_done"}, longint'(done_a), 0);
        chk({tag, "_prst"}, longint'(prst_a), 0);
        chk({tag, "_idx"},  longint'(idx_a),  0);
    endtask

    initial begin
        int unsigned exp_up [5];
        int unsigned exp_dn [3];
        int unsigned fs, fe, st, span, run;
        exp_up = '{1000, 1003, 1006, 1009, 1010};
        exp_dn = '{500, 495, 490};

        rst_n = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Up sweep, literal expectations
        set_cfg(1000, 1010, 3, 4, 1'b0);
        go();
        for (int unsigned p = 0; p < 5; p++) begin
            chk("up_fre", longint'(fre_a), longint'(exp_up[p]));
            chk("up_idx", longint'(idx_a), longint'(p));
            chk("up_prst", longint'(prst_a), (p == 0) ? 1 : 0);
            repeat (4) tick();
        end
        chk("up_done", longint'(done_a), 1);
        chk("up_busy", longint'(busy_a), 0);
        chk("up_fre_hold", longint'(fre_a), 1010);

        // Down sweep with repeat, started in the cycle after done
        set_cfg(500, 490, 5, 0, 1'b1);
        go();
        for (int unsigned i = 0; i < 7; i++) begin
            chk("dn_fre", longint'(fre_a), longint'(exp_dn[i % 3]));
            chk("dn_prst", longint'(prst_a), (i % 3 == 0) ? 1 : 0);
            chk("dn_done", longint'(done_a), 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", longint'(busy_a), 0);
        chk("stop_done", longint'(done_a), 0);
        chk("stop_fre", longint'(fre_a), 495);

        // start and stop together in idle
        set_cfg(10, 20, 1, 1, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("race_busy", longint'(busy_a), 0);
        chk("race_fre", longint'(fre_a), 495);

        // Degenerate single-point sweeps
        set_cfg(100, 200, 0, 2, 1'b0);
        go();
        chk("step0_fre", longint'(fre_a), 100);
        chk("step0_busy", longint'(busy_a), 1);
        tick();
        chk("step0_busy2", longint'(busy_a), 1);
        tick();
        chk("step0_done", longint'(done_a), 1);
        set_cfg(7, 7, 9, 2, 1'b0);
        go();
        chk("eq_fre", longint'(fre_a), 7);
        tick();
        tick();
        chk("eq_done", longint'(done_a), 1);
        chk("eq_fre_hold", longint'(fre_a), 7);

        // Phase reset on every point for the STEP_RST instance
        set_cfg(0, 20, 10, 3, 1'b0);
        go();
        for (int unsigned p = 0; p < 3; p++) begin
            chk("sr_prst", longint'(prst_b), 1);
            chk("sr_fre", longint'(fre_b), longint'(10 * p));
            tick();
            chk("sr_prst_low", longint'(prst_b), 0);
            tick();
            tick();
        end
        chk("sr_done", longint'(done_b), 1);

        // Reset mid-sweep, then a clean restart
        set_cfg(1000, 1010, 3, 4, 1'b0);
        go();
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        go();
        chk("rst_restart_fre", longint'(fre_a), 1000);
        chk("rst_restart_prst", longint'(prst_a), 1);
        wait_idle(100);

        // start while busy with a different configuration
        set_cfg(200, 230, 10, 2, 1'b0);
        go();
        repeat (3) tick();
        set_cfg(5000, 6000, 1, 1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(100);
        chk("busy_start_fre", longint'(fre_a), 230);

        // Steps that would wrap 25 bits
        set_cfg(FMAX - 99, FMAX, FMAX, 1, 1'b0);
        go();
        tick();
        chk("wrap_up_fre", longint'(fre_a), longint'(FMAX));
        wait_idle(10);
        set_cfg(50, 0, FMAX, 1, 1'b0);
        go();
        tick();
        chk("wrap_dn_fre", longint'(fre_a), 0);
        wait_idle(10);

        // Randomized sweeps
        for (int unsigned n = 0; n < 40; n++) begin
            fs   = $urandom & FMAX;
            span = $urandom_range(0, 200);
            if ($urandom_range(0, 1) == 1)
                fe = (fs + span > FMAX) ? FMAX : fs + span;
            else
                fe = (fs < span) ? 0 : fs - span;
            if ($urandom_range(0, 9) == 0)      st = 0;
            else if ($urandom_range(0, 7) == 0) st = $urandom & FMAX;
            else                                st = $urandom_range(1, 40);
            set_cfg(fs, fe, st, $urandom_range(0, 4), $urandom_range(0, 3) == 0);
            go();
            if (repeat_en || $urandom_range(0, 4) == 0) begin
                run = $urandom_range(1, 60);
                for (int unsigned c = 0; c < run; c++) begin
                    if ($urandom_range(0, 15) == 0) begin
                        set_cfg($urandom & FMAX, $urandom & FMAX, $urandom_range(0, 9),
                                $urandom_range(0, 3), $urandom_range(0, 1) == 1);
                        start = 1'b1;
                    end
                    tick();
                    start = 1'b0;
                end
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end else begin
                wait_idle(2000);
            end
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
